sfifo_wr_arb: RTL and testbench
===============================

Name: sfifo_wr_arb

Overview:
- Round-robin arbiter that shares the write port of the SYNC_FIFO between NREQ command producers, such as the host packet parser and the local jog/probe sequencer.
- Multi-word commands are packet-atomic: once a producer is granted, its words are never interleaved with another producer's words until it marks the last word.
- Sits in the wishbone clock domain, upstream of the SYNC_FIFO whose read side is drained by the sfifo interface block.

Parameters:
NREQ, 2, number of requesters (2..8)
SFIFO_DW, 16, FIFO word width
MAX_PKT, 64, maximum words per packet before forced release
CNT_W, 32, width of the accepted-word statistics counter

Ports:
wb_clk_i  input  1  single clock
wb_rst_ni  input  1  asynchronous, active-low reset
req_i  input  NREQ  per-requester word valid
req_last_i  input  NREQ  per-requester last-word-of-packet flag
req_dat_i  input  NREQ*SFIFO_DW  packed word data; requester k occupies bits [k*SFIFO_DW +: SFIFO_DW]
req_ack_o  output  NREQ  word accepted this cycle (combinational)
grant_o  output  NREQ  one-hot current owner; 0 when idle (registered)
sfifo_wr_o  output  1  FIFO write strobe (combinational)
sfifo_do  output  SFIFO_DW  FIFO write data (combinational)
sfifo_full_i  input  1  FIFO full
busy_o  output  1  packet in progress
pkt_err_o  output  1  sticky: MAX_PKT exceeded
err_clr_i  input  1  clears pkt_err_o
word_cnt_o  output  CNT_W  total words written, wraps

Behaviour:
- Reset values (asynchronous, wb_rst_ni=0):
  - state=IDLE; grant_o=0; busy_o=0; pkt_err_o=0; word_cnt_o=0.
  - last owner pointer=NREQ-1, so requester 0 has top priority first.
- Combinational outputs are 0 during reset.
- States:
  - IDLE: no owner.
  - BUSY: owner latched, packet in progress.
- IDLE transition:
  - If any req_i bit is set, pick the first set bit scanning from (last_owner+1) mod NREQ upward with wrap.
  - Latch it as owner, set grant_o one-hot, set busy_o=1, go to BUSY.
  - This arbitration cycle takes 1 cycle; no word is accepted in IDLE.
- Word acceptance: accept = (state==BUSY) & req_i[owner] & ~sfifo_full_i.
  - On accept: req_ack_o[owner]=1, sfifo_wr_o=1, sfifo_do=req_dat_i of the owner, all in the same cycle.
  - Otherwise: sfifo_wr_o=0, all acks 0, sfifo_do=0.
- Requester handshake: hold req_i, data and last stable until acked. The next word may be presented in the cycle after the ack.
- Throughput: 1 word per cycle while the owner is valid and the FIFO is not full. Latency from req_i in IDLE to first ack is 1 cycle.
- BUSY exit:
  - On accept with req_last_i[owner]=1: go to IDLE, last_owner=owner, grant_o=0, busy_o=0.
  - Packet word counter pkt_cnt (reset on grant) increments on each accept.
- Forced release: if an accept occurs with pkt_cnt==MAX_PKT-1 and last=0:
  - go to IDLE and set pkt_err_o=1.
  - The word itself is still written.
- Owner drops req_i mid-packet: stay in BUSY and keep the lock; other requesters wait indefinitely.
- FIFO full: accept stalls; state and owner are unchanged; no ack.
- word_cnt_o increments by 1 on every sfifo_wr_o and wraps at 2^CNT_W.
- pkt_err_o: err_clr_i clears it. If err_clr_i coincides with a new error in the same cycle, set wins.
- A single requester with back-to-back packets is re-granted after one IDLE cycle, provided it is the only requester.
- Reset mid-packet: immediate return to IDLE; the partial packet is left in the FIFO. Upstream recovery is out of scope.

Decomposition:
- Shared package sfifo_pkg holds:
  - SFIFO_DW default.
  - State encoding localparams (ST_IDLE, ST_BUSY).
  - Bit-offset macros shared with the sfifo interface block.
- One sub-module, rr_pick: a combinational round-robin first-set-bit finder with inputs req and last_owner, and output a one-hot grant. It is reusable elsewhere.

Test Plan:
- Reset, then req_i=01 with a 3-word packet (A1,A2,A3, last on A3):
  - grant_o=01 one cycle after req.
  - Three consecutive sfifo_wr_o with those data.
  - Then IDLE; word_cnt_o=3.
- req_i=11 simultaneously, each sending 2-word packets:
  - Order is req0 packet, then req1 packet, then req0 again.
  - Words are never interleaved; 1 IDLE cycle between packets.
- sfifo_full_i=1 for 5 cycles mid-packet:
  - No acks and no writes during those cycles.
  - Resumes on the first non-full cycle with the same word.
- Owner deasserts req_i for 4 cycles mid-packet while req1 is pending:
  - grant_o stays on the owner; req1 gets no ack until the owner's last word.
- MAX_PKT=4, owner sends 6 words with no last:
  - 4 words are written, then pkt_err_o=1 and grant passes to the other requester.
  - err_clr_i clears the flag.
- Assert wb_rst_ni=0 asynchronously mid-packet:
  - All outputs go to 0 immediately.
  - After release, req0 wins first.

Source files
------------

// File: rtl/sfifo_pkg.sv
// rtl/sfifo_pkg.sv - shared types and constants for the sync FIFO command path
package sfifo_pkg;

  // Default command word width on the FIFO write port.
  localparam int SFIFO_DW = 16;

  // Write-port arbiter states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } sfifo_state_e;

  // Field offsets inside a command word, shared with the FIFO read-side decoder.
  localparam int SFIFO_OP_LSB  = 12;
  localparam int SFIFO_OP_W    = 4;
  localparam int SFIFO_ARG_LSB = 0;
  localparam int SFIFO_ARG_W   = 12;

  // Index width for a vector of n requesters (never below 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Opcode field of a command word.
  function automatic logic [SFIFO_OP_W-1:0] sfifo_op(input logic [SFIFO_DW-1:0] w);
    return w[SFIFO_OP_LSB +: SFIFO_OP_W];
  endfunction

  // Argument field of a command word.
  function automatic logic [SFIFO_ARG_W-1:0] sfifo_arg(input logic [SFIFO_DW-1:0] w);
    return w[SFIFO_ARG_LSB +: SFIFO_ARG_W];
  endfunction

endpackage

// File: rtl/sfifo_wr_arb_rr_pick.sv
// rtl/sfifo_wr_arb_rr_pick.sv - combinational round-robin first-set-bit finder
module rr_pick
  import sfifo_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [NREQ-1:0] gnt
);

  logic [IW-1:0] idx;
  logic          found;

  // Scan upward from the requester after last_owner, wrapping, and keep the first hit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(last_owner) + i) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfifo_wr_arb.sv
// rtl/sfifo_wr_arb.sv - packet-atomic round-robin arbiter for the sync FIFO write port
module sfifo_wr_arb #(
  parameter int NREQ     = 2,
  parameter int SFIFO_DW = sfifo_pkg::SFIFO_DW,
  parameter int MAX_PKT  = 64,
  parameter int CNT_W    = 32
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          req_last_i,
  input  logic [NREQ*SFIFO_DW-1:0] req_dat_i,
  output logic [NREQ-1:0]          req_ack_o,
  output logic [NREQ-1:0]          grant_o,
  output logic                     sfifo_wr_o,
  output logic [SFIFO_DW-1:0]      sfifo_do,
  input  logic                     sfifo_full_i,
  output logic                     busy_o,
  output logic                     pkt_err_o,
  input  logic                     err_clr_i,
  output logic [CNT_W-1:0]         word_cnt_o
);
  import sfifo_pkg::*;

  localparam int IW = idx_w(NREQ);
  localparam int PW = idx_w(MAX_PKT);

  sfifo_state_e      state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  logic [NREQ-1:0]     pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic [SFIFO_DW-1:0] dat_arr [NREQ];
  logic                accept;
  logic                own_last;
  logic                max_hit;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req        (req_i),
    .last_owner (last_q),
    .gnt        (pick_gnt)
  );

  for (genvar k = 0; k < NREQ; k++) begin : g_dat
    assign dat_arr[k] = req_dat_i[k*SFIFO_DW +: SFIFO_DW];
  end

  // Convert the one-hot pick into an owner index.
  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_gnt[k]) pick_idx = IW'(k);
    end
  end

  assign accept   = (state_q == ST_BUSY) & req_i[owner_q] & ~sfifo_full_i;
  assign own_last = req_last_i[owner_q];
  assign max_hit  = (pkt_cnt_q == PW'(MAX_PKT - 1));

  assign req_ack_o  = grant_q & {NREQ{accept}};
  assign sfifo_wr_o = accept;
  assign sfifo_do   = accept ? dat_arr[owner_q] : '0;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q == ST_BUSY);
  assign pkt_err_o  = err_q;
  assign word_cnt_o = word_cnt_q;

  // Next-state: arbitrate in IDLE, stream the owner's words in BUSY until last or forced release.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    grant_d    = grant_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_d      = err_q & ~err_clr_i;
    word_cnt_d = word_cnt_q + CNT_W'(accept);
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d   = ST_BUSY;
          owner_d   = pick_idx;
          grant_d   = pick_gnt;
          pkt_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (accept) begin
          pkt_cnt_d = pkt_cnt_q + PW'(1);
          if (own_last || max_hit) begin
            state_d = ST_IDLE;
            last_d  = owner_q;
            grant_d = '0;
          end
          // An overlong packet still gets its word written; the error set beats a clear.
          if (!own_last && max_hit) err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; the last-owner pointer resets so requester 0 wins first.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_q     <= IW'(NREQ - 1);
      grant_q    <= '0;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// tb/tb_sfifo_wr_arb.sv - self-checking bench for the FIFO write-port arbiter
module tb_sfifo_wr_arb;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int MAXP = 4;
  localparam int CW   = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]    req, last;
  logic [NREQ*DW-1:0] dat;
  logic               req_v [NREQ];
  logic               last_v [NREQ];
  logic [DW-1:0]      dat_v [NREQ];
  logic               full = 1'b0;
  logic               err_clr = 1'b0;

  logic [NREQ-1:0] ack, grant;
  logic            sfifo_wr, busy, pkt_err;
  logic [DW-1:0]   sfifo_do;
  logic [CW-1:0]   word_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] log_dat [$];
  int            log_cyc [$];
  logic [DW-1:0] exp_q [$];
  bit done = 0;

  sfifo_wr_arb #(
    .NREQ(NREQ), .SFIFO_DW(DW), .MAX_PKT(MAXP), .CNT_W(CW)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_i(req), .req_last_i(last), .req_dat_i(dat),
    .req_ack_o(ack), .grant_o(grant),
    .sfifo_wr_o(sfifo_wr), .sfifo_do(sfifo_do), .sfifo_full_i(full),
    .busy_o(busy), .pkt_err_o(pkt_err), .err_clr_i(err_clr),
    .word_cnt_o(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req[k] = req_v[k];
      last[k] = last_v[k];
      dat[k*DW +: DW] = dat_v[k];
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = none), rotating priority, packet length, error, count.
  int m_owner = -1, m_last = NREQ - 1, m_pkt = 0, m_cnt = 0, mk;
  bit m_err = 0, m_acc, m_newerr;
  logic [NREQ-1:0] e_grant, e_ack;
  logic            e_wr;
  logic [DW-1:0]   e_do;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_last = NREQ - 1; m_pkt = 0; m_cnt = 0; m_err = 0;
      m_acc = 0; e_grant = '0; e_ack = '0; e_wr = 0; e_do = '0;
    end else begin
      m_acc   = (m_owner >= 0) && req[m_owner] && !full;
      e_grant = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
      e_ack   = m_acc ? e_grant : '0;
      e_wr    = m_acc;
      e_do    = m_acc ? dat_v[m_owner] : '0;
    end
    check("cyc_grant", grant, e_grant);
    check("cyc_ack", ack, e_ack);
    check("cyc_wr", sfifo_wr, e_wr);
    check("cyc_do", sfifo_do, e_do);
    check("cyc_busy", busy, m_owner >= 0);
    check("cyc_err", pkt_err, m_err);
    check("cyc_cnt", word_cnt, m_cnt);
    if (sfifo_wr) begin
      log_dat.push_back(sfifo_do);
      log_cyc.push_back(cyc);
    end
    if (rst_n) begin
      m_newerr = 0;
      if (m_owner < 0) begin
        for (int i = 1; i <= NREQ; i++) begin
          mk = (m_last + i) % NREQ;
          if (m_owner < 0 && req[mk]) begin
            m_owner = mk;
            m_pkt = 0;
          end
        end
      end else if (m_acc) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_pkt++;
        if (last[m_owner]) begin
          m_last = m_owner; m_owner = -1;
        end else if (m_pkt == MAXP) begin
          m_newerr = 1; m_last = m_owner; m_owner = -1;
        end
      end
      if (m_newerr) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; full = 0; err_clr = 0;
    for (int k = 0; k < NREQ; k++) begin req_v[k] = 0; last_v[k] = 0; end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Present one word and hold it until acked; returns one cycle after the ack.
  task automatic send_word(input int k, input logic [DW-1:0] d, input logic l);
    bit got = 0;
    req_v[k] = 1; dat_v[k] = d; last_v[k] = l;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (ack[k]) begin got = 1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: req%0d word %0h got no ack, required ack within 400 cycles", k, d);
    end
    @(posedge clk); #1;
    req_v[k] = 0; last_v[k] = 0;
  endtask

  task automatic send_pkt(input int k, input logic [DW-1:0] base, input int len, input bit with_last);
    for (int i = 0; i < len; i++)
      send_word(k, base + DW'(i), with_last && (i == len - 1));
  endtask

  task automatic check_log(input string nm);
    check({nm, "_len"}, log_dat.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_dat.size(); i++)
      check($sformatf("%s_w%0d", nm, i), log_dat[i], exp_q[i]);
  endtask

  task automatic producer(input int k, input int npkt);
    int len;
    for (int p = 0; p < npkt; p++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send_word(k, DW'((k << 12) | ((p & 63) << 4) | i), i == len - 1);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin req_v[k] = 0; last_v[k] = 0; dat_v[k] = '0; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", word_cnt, 0);

    // Single 3-word packet from requester 0.
    @(posedge clk); #1;
    req_v[0] = 1; dat_v[0] = 16'hA001; last_v[0] = 0;
    @(negedge clk);
    check("t1_idle_grant", grant, 0);
    check("t1_idle_wr", sfifo_wr, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_grant", grant, 3'b001);
    check("t1_do1", sfifo_do, 16'hA001);
    @(posedge clk); #1; dat_v[0] = 16'hA002;
    @(negedge clk);
    check("t1_do2", sfifo_do, 16'hA002);
    @(posedge clk); #1; dat_v[0] = 16'hA003; last_v[0] = 1;
    @(negedge clk);
    check("t1_do3", sfifo_do, 16'hA003);
    check("t1_wr3", sfifo_wr, 1);
    @(posedge clk); #1; req_v[0] = 0; last_v[0] = 0;
    @(negedge clk);
    check("t1_end_grant", grant, 0);
    check("t1_end_busy", busy, 0);
    check("t1_end_cnt", word_cnt, 3);

    // Two requesters contending: req0, req1, req0, one idle cycle between packets.
    do_reset();
    log_dat.delete(); log_cyc.delete();
    fork
      begin send_pkt(0, 16'h1000, 2, 1); send_pkt(0, 16'h1010, 2, 1); end
      send_pkt(1, 16'h2000, 2, 1);
    join
    exp_q = '{16'h1000, 16'h1001, 16'h2000, 16'h2001, 16'h1010, 16'h1011};
    check_log("t2");
    if (log_cyc.size() == 6) begin
      check("t2_gap0", log_cyc[1] - log_cyc[0], 1);
      check("t2_gap1", log_cyc[2] - log_cyc[1], 2);
      check("t2_gap2", log_cyc[3] - log_cyc[2], 1);
      check("t2_gap3", log_cyc[4] - log_cyc[3], 2);
    end

    // FIFO full for 5 cycles mid-packet; the packet ends exactly at MAX_PKT words.
    log_dat.delete();
    send_word(0, 16'h3000, 0);
    send_word(0, 16'h3001, 0);
    full = 1; req_v[0] = 1; dat_v[0] = 16'h3002; last_v[0] = 0;
    repeat (5) begin
      @(negedge clk);
      check("t3_full_ack", ack, 0);
      check("t3_full_wr", sfifo_wr, 0);
      check("t3_full_grant", grant, 3'b001);
      @(posedge clk); #1;
    end
    full = 0;
    @(negedge clk);
    check("t3_resume_wr", sfifo_wr, 1);
    check("t3_resume_do", sfifo_do, 16'h3002);
    @(posedge clk); #1;
    send_word(0, 16'h3003, 1);
    check("t3_no_err", pkt_err, 0);

    // Owner pauses 4 cycles mid-packet while req1 waits.
    log_dat.delete();
    fork
      begin
        send_word(0, 16'h4000, 0);
        send_word(0, 16'h4001, 0);
        repeat (4) begin
          @(negedge clk);
          check("t4_hold_grant", grant, 3'b001);
          check("t4_no_ack1", ack[1], 0);
          @(posedge clk); #1;
        end
        send_word(0, 16'h4002, 1);
      end
      begin @(posedge clk); #1; send_pkt(1, 16'h5000, 2, 1); end
    join
    exp_q = '{16'h4000, 16'h4001, 16'h4002, 16'h5000, 16'h5001};
    check_log("t4");

    // Overlong packet: forced release after MAX_PKT words, other requester gets in.
    log_dat.delete();
    fork
      begin send_pkt(0, 16'h6000, 6, 0); send_word(0, 16'h6006, 1); end
      begin repeat (2) begin @(posedge clk); #1; end send_pkt(1, 16'h7000, 2, 1); end
    join
    exp_q = '{16'h6000, 16'h6001, 16'h6002, 16'h6003, 16'h7000, 16'h7001,
              16'h6004, 16'h6005, 16'h6006};
    check_log("t5");
    check("t5_err_set", pkt_err, 1);
    err_clr = 1;
    @(negedge clk);
    check("t5_err_hold", pkt_err, 1);
    @(posedge clk); #1; err_clr = 0;
    @(negedge clk);
    check("t5_err_clr", pkt_err, 0);

    // Asynchronous reset mid-packet, then requester 0 wins first.
    @(posedge clk); #1;
    send_word(0, 16'h8000, 0);
    req_v[0] = 1; dat_v[0] = 16'h8001;
    req_v[1] = 1; dat_v[1] = 16'h9000; last_v[1] = 1;
    #1 check("t6_pre_wr", sfifo_wr, 1);
    #1 rst_n = 0;
    #1;
    check("t6_rst_grant", grant, 0);
    check("t6_rst_ack", ack, 0);
    check("t6_rst_wr", sfifo_wr, 0);
    check("t6_rst_do", sfifo_do, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cnt", word_cnt, 0);
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    check("t6_idle_grant", grant, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_req0_first", grant, 3'b001);

    // Randomized traffic from all requesters with random full and error-clear.
    do_reset();
    fork
      begin
        fork
          producer(0, 25);
          producer(1, 25);
          producer(2, 25);
        join
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          full = ($urandom_range(0, 3) == 0);
          err_clr = ($urandom_range(0, 9) == 0);
        end
        full = 0; err_clr = 0;
      end
    join
    repeat (3) @(negedge clk);
    check("rnd_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
